delay_chain_monitor: RTL and testbench
======================================

// Module: delay_chain_monitor
// PURPOSE
//  Multi-channel successor to the single fixed gate-delay path. Each channel is a DEPTH-stage NAND
//  delay chain with a register on every stage output (tap). The block launches a transition into each
//  chain and captures the taps one clock later. It averages the arrival depth over 2^AVG_LOG2
//  samples and flags channels whose delay drifts from a calibrated baseline.
//  Sits beside the target logic as a delay-tamper/aging monitor, reporting to the control register block.
// PARAMETERS
//  NUM_CH      4     number of independent delay chains (>=1)
//  DEPTH       32    stages per chain (>=2)
//  CNT_W       6     width of tap count; must be >= clog2(DEPTH+1)
//  AVG_LOG2    3     log2 of samples averaged per channel (0..4)
//  TOL         2     allowed |avg - baseline| before alarm
//  STAGE_DELAY 0.45  sim-only per-stage delay in ns; ignored by synthesis
// PORTS
//  clk         in   1           single clock; all flops rising-edge
//  rst         in   1           synchronous, active-high reset
//  VCC         in   1           external tie-high; constant input of every chain NAND (keeps chains unoptimised)
//  GND         in   1           external tie-low; OR'd with launch bit at each chain head
//  start       in   1           begin one run over all channels; sampled only in IDLE
//  cal         in   1           sampled with start: 1 = calibration run, 0 = monitor run
//  busy        out  1           high from first LAUNCH cycle until done
//  done        out  1           1-cycle pulse when the run completes
//  meas        out  CNT_W       averaged tap count of the last channel finished
//  meas_ch     out  clog2(NUM_CH) channel index of meas (width 1 when NUM_CH==1)
//  meas_valid  out  1           1-cycle pulse when meas/meas_ch update
//  base_valid  out  1           at least one calibration run has completed
//  alarm       out  NUM_CH      sticky per-channel drift flag
// BEHAVIOUR
//  Chain: stage i = nand(stage i-1, VCC); stage 0 input = or(launch[ch], GND). Each stage inverts.
//   Expected value of tap i after a launch = launch[ch] ^ ((i+1) & 1).
//  Taps are captured into tap_q[ch] only in CAPTURE for the active channel.
//  Count = number of consecutive matching taps from tap 0. The first mismatch ends the count, so
//   later bubbles are ignored. All DEPTH match -> count = DEPTH (saturates).
//  FSM: IDLE -> LAUNCH -> CAPTURE -> ENCODE -> (LAUNCH | COMPARE) -> (LAUNCH next ch | IDLE).
//   IDLE: start=1 latches cal into cal_q, sets ch=0, acc=0, sample=0 -> LAUNCH.
//   LAUNCH: launch[ch] toggles at cycle end.
//   CAPTURE: taps registered at cycle end; the chain gets exactly one clock period to propagate.
//   ENCODE: acc += count; sample++. If sample was 2^AVG_LOG2-1 -> COMPARE, else -> LAUNCH.
//   COMPARE: avg = acc >> AVG_LOG2 (truncate; acc width CNT_W+AVG_LOG2, no overflow).
//    The following update at cycle end:
//    - meas <= avg; meas_ch <= ch; meas_valid pulses in the next cycle.
//    - If cal_q: baseline[ch] <= avg; alarm[ch] <= 0.
//    - Else if base_valid and |avg - baseline[ch]| > TOL (strict): alarm[ch] <= 1.
//    - Then acc=0, sample=0. If ch < NUM_CH-1: ch++ -> LAUNCH, else -> IDLE.
//  done pulses in the first IDLE cycle after the last COMPARE. busy is low in that cycle.
//   base_valid sets in that same cycle if cal_q.
//  Run length: busy high for exactly NUM_CH*(3*2^AVG_LOG2+1) cycles (defaults: 100).
//  start while busy: ignored, not queued. start and done in the same cycle: the new run is accepted.
//  Monitor run before any calibration: meas updates, alarms never set.
//  alarm clears only on rst or on a calibration run (per channel, at its COMPARE).
//  Reset (any state, mid-run included): FSM -> IDLE.
//   Cleared: launch, tap_q, acc, sample, ch, meas, meas_ch, baselines, base_valid, alarm.
//   busy, done and meas_valid go to 0. No done pulse for an aborted run.
//  Sim hook: real array stage_dly[NUM_CH] is initialised to STAGE_DELAY. The bench may overwrite it
//   hierarchically between runs.
// TESTING (clk period 10 ns, defaults)
//  1 Reset: rst 3 cycles -> all outputs 0; start while rst=1 is ignored, busy stays 0.
//  2 Calibration: start+cal, STAGE_DELAY 0.45 -> 4 meas_valid pulses, meas=22, ch 0..3.
//     done 100 cycles after busy rises; base_valid=1; alarm=0.
//  3 Tamper: stage_dly[2]=0.55, monitor run -> meas ch2=18, alarm=4'b0100.
//     Further monitor runs keep alarm set; a calibration run clears it.
//  4 Tolerance edge: stage_dly[1]=0.5 (count 20, diff 2) -> alarm[1]=0.
//  5 Saturation and pre-cal: fresh reset, stage_dly all 0.2, monitor run -> meas=32, alarm=0, base_valid=0.
//  6 Mid-run reset: rst at cycle 40 of a run -> no done, base_valid=0; new start completes normally.

Source files
------------

// File: rtl/delay_chain_monitor.sv
// Multi-channel NAND delay-chain monitor: launches a transition per chain, counts arrival
// depth, averages it and raises sticky alarms when a channel drifts from its baseline.
module delay_chain_monitor #(
  parameter int  NUM_CH      = 4,
  parameter int  DEPTH       = 32,
  parameter int  CNT_W       = 6,
  parameter int  AVG_LOG2    = 3,
  parameter int  TOL         = 2,
  parameter real STAGE_DELAY = 0.45,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              VCC,
  input  logic              GND,
  input  logic              start,
  input  logic              cal,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  meas,
  output logic [CHW-1:0]    meas_ch,
  output logic              meas_valid,
  output logic              base_valid,
  output logic [NUM_CH-1:0] alarm
);

  localparam int AW = CNT_W + AVG_LOG2;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SW-1:0]  SLAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [CHW-1:0] CLAST = CHW'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] TOLV = CNT_W'(TOL);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    ENCODE,
    COMPARE
  } state_t;

  state_t state, nstate;

  logic [NUM_CH-1:0] launch;
  logic [DEPTH-1:0]  stg   [NUM_CH];
  logic [DEPTH-1:0]  tap_q [NUM_CH];
  logic [CNT_W-1:0]  baseline [NUM_CH];
  logic [AW-1:0]     acc;
  logic [SW-1:0]     sample;
  logic [CHW-1:0]    ch;
  logic              cal_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  avg;
  logic              run;
  logic              over;

  // Propagation model: per-stage delay and the time the launch edge left.
  real stage_dly [NUM_CH] = '{default: STAGE_DELAY};
  real t_launch;

  always_comb begin : chain
    logic p;
    p = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      p = launch[c] | GND;
      for (int i = 0; i < DEPTH; i++) begin
        p = ~(p & VCC);
        stg[c][i] = p;
      end
    end
  end

  // Thermometer encode: first mismatch from tap 0 ends the count.
  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (run && (tap_q[ch][i] == (launch[ch] ^ ~i[0])))
        cnt = cnt + CNT_W'(1);
      else
        run = 1'b0;
    end
  end

  always_comb begin
    avg  = CNT_W'(acc >> AVG_LOG2);
    over = 1'b0;
    if (avg > baseline[ch])
      over = (avg - baseline[ch]) > TOLV;
    else
      over = (baseline[ch] - avg) > TOLV;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = LAUNCH;
      LAUNCH:  nstate = CAPTURE;
      CAPTURE: nstate = ENCODE;
      ENCODE:  nstate = (sample == SLAST) ? COMPARE : LAUNCH;
      COMPARE: nstate = (ch == CLAST) ? IDLE : LAUNCH;
      default: nstate = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      launch     <= '0;
      acc        <= '0;
      sample     <= '0;
      ch         <= '0;
      cal_q      <= 1'b0;
      meas       <= '0;
      meas_ch    <= '0;
      meas_valid <= 1'b0;
      done       <= 1'b0;
      base_valid <= 1'b0;
      alarm      <= '0;
      t_launch   <= 0.0;
      for (int c = 0; c < NUM_CH; c++) begin
        tap_q[c]    <= '0;
        baseline[c] <= '0;
      end
    end else begin
      meas_valid <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cal_q  <= cal;
            ch     <= '0;
            acc    <= '0;
            sample <= '0;
          end
        end
        LAUNCH: begin
          launch[ch] <= ~launch[ch];
          t_launch   <= $realtime;
        end
        CAPTURE: begin
          // Taps the edge has not reached still hold their pre-launch level.
          for (int i = 0; i < DEPTH; i++) begin
            if (real'(i + 1) * stage_dly[ch] <= $realtime - t_launch + 1.0e-6)
              tap_q[ch][i] <= stg[ch][i];
            else
              tap_q[ch][i] <= ~stg[ch][i];
          end
        end
        ENCODE: begin
          acc    <= acc + AW'(cnt);
          sample <= sample + 1'b1;
        end
        COMPARE: begin
          meas       <= avg;
          meas_ch    <= ch;
          meas_valid <= 1'b1;
          if (cal_q) begin
            baseline[ch] <= avg;
            alarm[ch]    <= 1'b0;
          end else if (base_valid && over) begin
            alarm[ch] <= 1'b1;
          end
          acc    <= '0;
          sample <= '0;
          if (ch == CLAST) begin
            done <= 1'b1;
            if (cal_q) base_valid <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_chain_monitor.sv
// Randomized bench for delay_chain_monitor against an arrival-depth reference model.
// Stage delays are held as integer hundredths of the clock unit; period is 10 units.
module tb_delay_chain_monitor;

  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 32;
  localparam int CNT_W    = 6;
  localparam int BUSY_CYC = NUM_CH * (3 * 8 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic VCC = 1'b1;
  logic GND = 1'b0;
  logic start = 1'b0;
  logic cal = 1'b0;
  logic busy, done, meas_valid, base_valid;
  logic [CNT_W-1:0]  meas;
  logic [1:0]        meas_ch;
  logic [NUM_CH-1:0] alarm;

  int checks = 0;
  int errors = 0;

  int dly  [NUM_CH];
  int base [NUM_CH];
  int expm [NUM_CH];
  bit bv;
  bit [NUM_CH-1:0] al;

  int nobs, bcyc;
  bit got_done;
  int obs_m [16];
  int obs_c [16];

  delay_chain_monitor dut (
    .clk(clk), .rst(rst), .VCC(VCC), .GND(GND),
    .start(start), .cal(cal), .busy(busy), .done(done),
    .meas(meas), .meas_ch(meas_ch), .meas_valid(meas_valid),
    .base_valid(base_valid), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic set_dly(input int c, input int h);
    dly[c] = h;
    dut.stage_dly[c] = real'(h) / 100.0;
  endtask

  task automatic model_reset();
    bv = 1'b0;
    al = '0;
    for (int c = 0; c < NUM_CH; c++) base[c] = 0;
  endtask

  // Arrival depth: stages whose cumulative delay fits in one 10-unit period.
  task automatic model_run(input bit c_run);
    int n, d;
    for (int c = 0; c < NUM_CH; c++) begin
      n = 1000 / dly[c];
      if (n > DEPTH) n = DEPTH;
      expm[c] = n;
      d = (n > base[c]) ? n - base[c] : base[c] - n;
      if (c_run) begin
        base[c] = n;
        al[c] = 1'b0;
      end else if (bv && d > 2) begin
        al[c] = 1'b1;
      end
    end
    if (c_run) bv = 1'b1;
  endtask

  task automatic run_collect(input logic c);
    start = 1'b1;
    cal = c;
    @(negedge clk);
    start = 1'b0;
    cal = 1'b0;
    nobs = 0;
    bcyc = 0;
    got_done = 1'b0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      if (busy) bcyc++;
      if (meas_valid && nobs < 16) begin
        obs_m[nobs] = int'(meas);
        obs_c[nobs] = int'(meas_ch);
        nobs++;
      end
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL run_timeout got busy_cycles=%0d exp done", bcyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    cal = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy got %0d exp 0", busy);
      end
    end
    checks++;
    if ({done, meas_valid, base_valid, meas, meas_ch, alarm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0",
               {done, meas_valid, base_valid, meas, meas_ch, alarm});
    end
    rst = 1'b0;
    start = 1'b0;
    cal = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %0d exp 0", busy);
    end
    model_reset();
  endtask

  task automatic test_calibration();
    for (int c = 0; c < NUM_CH; c++) set_dly(c, 45);
    run_collect(1'b1);
    model_run(1'b1);
    checks++;
    if (bcyc !== BUSY_CYC) begin
      errors++;
      $display("FAIL cal_busy_len got %0d exp %0d", bcyc, BUSY_CYC);
    end
    checks++;
    if (nobs !== NUM_CH) begin
      errors++;
      $display("FAIL cal_pulses got %0d exp %0d", nobs, NUM_CH);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_m[k] !== expm[k] || obs_c[k] !== k) begin
        errors++;
        $display("FAIL cal_meas ch%0d got %0d/%0d exp %0d/%0d",
                 k, obs_m[k], obs_c[k], expm[k], k);
      end
    end
    checks++;
    if (base_valid !== bv || alarm !== al) begin
      errors++;
      $display("FAIL cal_flags got bv=%0d al=%b exp bv=%0d al=%b",
               base_valid, alarm, bv, al);
    end
  endtask

  task automatic test_tamper();
    set_dly(2, 55);
    for (int r = 0; r < 3; r++) begin
      run_collect(r == 2);
      model_run(r == 2);
      checks++;
      if (nobs !== NUM_CH || obs_m[2] !== expm[2]) begin
        errors++;
        $display("FAIL tamper_meas run%0d got %0d exp %0d", r, obs_m[2], expm[2]);
      end
      checks++;
      if (alarm !== al) begin
        errors++;
        $display("FAIL tamper_alarm run%0d got %b exp %b", r, alarm, al);
      end
    end
  endtask

  task automatic test_tolerance();
    int hs [2] = '{50, 52};
    for (int c = 0; c < NUM_CH; c++) set_dly(c, 45);
    run_collect(1'b1);
    model_run(1'b1);
    for (int r = 0; r < 2; r++) begin
      set_dly(1, hs[r]);
      run_collect(1'b0);
      model_run(1'b0);
      checks++;
      if (obs_m[1] !== expm[1] || alarm !== al) begin
        errors++;
        $display("FAIL tol_edge dly%0d got %0d/%b exp %0d/%b",
                 hs[r], obs_m[1], alarm, expm[1], al);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    for (int c = 0; c < NUM_CH; c++) set_dly(c, 40 + 5 * c);
    start = 1'b1;
    cal = 1'b1;
    bcyc = 0;
    seen = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 400 && !seen; k++) begin
      if (busy) bcyc++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    model_run(1'b1);
    checks++;
    if (!seen || bcyc !== BUSY_CYC) begin
      errors++;
      $display("FAIL b2b_first got done=%0d len=%0d exp 1/%0d", seen, bcyc, BUSY_CYC);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got busy=%0d exp 1", busy);
    end
    start = 1'b0;
    cal = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    model_run(1'b1);
    checks++;
    if (!seen || base_valid !== bv || alarm !== al) begin
      errors++;
      $display("FAIL b2b_second got done=%0d bv=%0d al=%b exp 1/%0d/%b",
               seen, base_valid, alarm, bv, al);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < NUM_CH; c++) set_dly(c, 20);
    run_collect(1'b0);
    model_run(1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_m[k] !== expm[k]) begin
        errors++;
        $display("FAIL sat_meas ch%0d got %0d exp %0d", k, obs_m[k], expm[k]);
      end
    end
    checks++;
    if (alarm !== al || base_valid !== bv) begin
      errors++;
      $display("FAIL sat_flags got al=%b bv=%0d exp al=%b bv=%0d",
               alarm, base_valid, al, bv);
    end
  endtask

  task automatic test_midrun_reset();
    int dn;
    for (int c = 0; c < NUM_CH; c++) set_dly(c, 45);
    start = 1'b1;
    cal = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cal = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({busy, done, meas_valid, base_valid, meas, alarm} !== '0) begin
      errors++;
      $display("FAIL midrun_clear got %0h exp 0",
               {busy, done, meas_valid, base_valid, meas, alarm});
    end
    dn = 0;
    for (int k = 0; k < 120; k++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn !== 0 || base_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_nodone got done=%0d bv=%0d exp 0/0", dn, base_valid);
    end
    run_collect(1'b1);
    model_run(1'b1);
    checks++;
    if (bcyc !== BUSY_CYC || obs_m[3] !== expm[3] || base_valid !== bv) begin
      errors++;
      $display("FAIL midrun_rerun got len=%0d m3=%0d bv=%0d exp %0d/%0d/%0d",
               bcyc, obs_m[3], base_valid, BUSY_CYC, expm[3], bv);
    end
  endtask

  task automatic test_random();
    bit c_run;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NUM_CH; c++) set_dly(c, int'($urandom_range(70, 15)));
      c_run = ($urandom_range(3, 0) == 0);
      run_collect(c_run);
      model_run(c_run);
      for (int k = 0; k < NUM_CH; k++) begin
        checks++;
        if (obs_m[k] !== expm[k] || obs_c[k] !== k) begin
          errors++;
          $display("FAIL rand_meas r%0d ch%0d got %0d/%0d exp %0d/%0d",
                   r, k, obs_m[k], obs_c[k], expm[k], k);
        end
      end
      checks++;
      if (alarm !== al || base_valid !== bv || bcyc !== BUSY_CYC) begin
        errors++;
        $display("FAIL rand_flags r%0d got al=%b bv=%0d len=%0d exp %b/%0d/%0d",
                 r, alarm, base_valid, bcyc, al, bv, BUSY_CYC);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) dly[c] = 45;
    model_reset();
    test_reset();
    test_calibration();
    test_tamper();
    test_tolerance();
    test_back_to_back();
    test_saturation();
    test_midrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
